// File: rtl/seg_pkg.sv
// Shared constants, snapshot record and hex glyph table for the seven-segment scanner.
// Segment encoding is active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package seg_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    // Digits that carry data; the rest of the frame stays dark.
    localparam int LAST_DATA_DIGIT  = 5;
    // Digits 0-3 show key/ASCII and go dark while no key is held.
    localparam int LAST_BLANK_DIGIT = 3;

    typedef struct packed {
        logic [7:0] key;
        logic [7:0] ascii;
        logic [7:0] count;
        logic       blank;
    } snapshot_t;

    localparam snapshot_t SNAP_ZERO = '0;

    function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
        logic [7:0] g;
        case (nibble)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment glyph; the decimal point is held off.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_n
);

    logic [7:0] glyph;

    always_comb begin
        glyph = hex_glyph(nibble);
    end

    assign seg_n = {1'b1, glyph[6:0]};

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit seven-segment driver showing key, ASCII and press count.
// Inputs are captured once per scan frame so a frame never mixes old and new values.
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int DIGITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key,
    input  logic [7:0] ascii,
    input  logic [7:0] count,
    input  logic       blank,
    output logic [7:0] an_n,
    output logic [7:0] seg_n,
    output logic       frame
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIG_W = $clog2(DIGITS);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [DIG_W-1:0] DIG_DATA  = DIG_W'(LAST_DATA_DIGIT);
    localparam logic [DIG_W-1:0] DIG_BLANK = DIG_W'(LAST_BLANK_DIGIT);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic [DIG_W-1:0] digit_reg;
    logic [DIG_W-1:0] digit_next;
    snapshot_t        snap_reg;
    snapshot_t        snap_next;
    logic [7:0]       an_n_reg;
    logic [7:0]       an_n_next;
    logic [7:0]       seg_n_reg;
    logic [7:0]       seg_n_next;
    logic             frame_reg;
    logic             frame_next;

    logic             tick;
    logic             frame_end;
    logic             lit;
    logic [3:0]       nibble;
    logic [7:0]       glyph_seg_n;

    // ---------------- divider, digit counter, snapshot ----------------
    assign tick      = (div_cnt_reg == DIV_MAX);
    assign frame_end = tick && (digit_reg == DIG_LAST);

    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
        digit_next   = tick ? digit_reg + 1'b1 : digit_reg;
        snap_next    = snap_reg;
        if (frame_end) begin
            snap_next = '{key: key, ascii: ascii, count: count, blank: blank};
        end
        frame_next = frame_end;
    end

    // ---------------- digit content ----------------
    always_comb begin
        nibble = 4'h0;
        case (digit_reg)
            DIG_W'(0): nibble = snap_reg.key[3:0];
            DIG_W'(1): nibble = snap_reg.key[7:4];
            DIG_W'(2): nibble = snap_reg.ascii[3:0];
            DIG_W'(3): nibble = snap_reg.ascii[7:4];
            DIG_W'(4): nibble = snap_reg.count[3:0];
            DIG_W'(5): nibble = snap_reg.count[7:4];
            default:   nibble = 4'h0;
        endcase
    end

    // Key/ASCII digits go dark while nothing is held; digits past the count are never lit.
    assign lit = (digit_reg <= DIG_DATA) && !(snap_reg.blank && (digit_reg <= DIG_BLANK));

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg_n  (glyph_seg_n)
    );

    assign seg_n_next = lit ? glyph_seg_n : SEG_OFF;

    // One-hot-low anode decode, gated by lit so dark digits keep every anode off.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
        assign an_n_next[gi] = ~(lit && (digit_reg == DIG_W'(gi)));
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_cnt_reg <= '0;
            digit_reg   <= '0;
            snap_reg    <= SNAP_ZERO;
            an_n_reg    <= AN_OFF;
            seg_n_reg   <= SEG_OFF;
            frame_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            digit_reg   <= digit_next;
            snap_reg    <= snap_next;
            an_n_reg    <= an_n_next;
            seg_n_reg   <= seg_n_next;
            frame_reg   <= frame_next;
        end
    end

    assign an_n  = an_n_reg;
    assign seg_n = seg_n_reg;
    assign frame = frame_reg;

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Display back-end for the PS/2 keyboard path. It sits directly downstream of the scan-code processing stage and consumes that stage's key code, ASCII code and press counter.
- Drives one 8-digit common-anode seven-segment display by time-multiplexing its digits.
- Takes a tear-free snapshot of the inputs once per scan frame.
- Converts each nibble to a hex glyph and blanks the key/ASCII digits while no key is held.

Parameters:
- CLK_DIV, 50000, clock cycles each digit stays lit; legal range 2..2^20.
- DIGITS, 8, digits scanned per frame; fixed at 8; any other value is illegal.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high despite the name (port named per codebase; when high, all state is cleared immediately).
- key  in  8  current scan code from the upstream stage.
- ascii  in  8  ASCII code of the current key.
- count  in  8  key-press counter.
- blank  in  1  high = no key held; blanks digits 0-3.
- an_n  out  8  digit select, active-low, one-hot-low; bit i = digit i.
- seg_n  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- frame  out  1  one-cycle pulse on the cycle the snapshot is taken.

Behaviour:
- Reset values: div_cnt=0, digit=0, snapshot (key, ascii, count, blank) = 0, an_n=8'hFF, seg_n=8'hFF, frame=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - tick = (div_cnt==CLK_DIV-1); on tick, div_cnt wraps to 0 and digit <= (digit+1) mod 8.
- Snapshot:
  - On a tick with digit==7, the snapshot registers load key/ascii/count/blank, and frame is registered high for exactly that next cycle.
  - Input changes mid-frame never appear until the next frame.
  - The first frame after reset shows the zero snapshot.
- Digit map (snapshot values):
  - 0 = key[3:0], 1 = key[7:4]
  - 2 = ascii[3:0], 3 = ascii[7:4]
  - 4 = count[3:0], 5 = count[7:4]
  - 6, 7 = unused
- Output registers, updated every clk, 1-cycle latency from digit/snapshot:
  - an_n = ~(1<<digit), except an_n=8'hFF for digits 6 and 7, and for digits 0-3 when snapshot blank=1.
  - seg_n = glyph(nibble) when lit, else 8'hFF; dp (bit 7) is always 1 (off).
- Glyphs (hex seg_n):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
- Counter wrap: count values are shown raw; 8'hFF displays "FF" and the following 8'h00 displays "00".
- Simultaneous events: a tick at digit 7 loads the snapshot and moves digit to 0 in the same edge. Digit 0's output (one cycle later) uses the new snapshot.
- Reset asserted mid-frame: all state returns to reset values asynchronously and the display goes dark (an_n=FF) immediately. Scanning restarts at digit 0 on the first edge after release.
- Never more than one an_n bit low at any cycle; this is an assertion in the bench.

Decomposition:
- Shared package seg_pkg holds:
  - constants SEG_OFF=8'hFF and AN_OFF=8'hFF;
  - the 16-entry glyph table as a constant function hex_glyph(nibble) returning 8 bits.
- One natural sub-module: hex7seg (combinational nibble -> seg_n, dp off), instanced once on the selected nibble.
- Divider, digit counter, snapshot and output registers stay in seg_scan.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles, any inputs -> an_n=FF, seg_n=FF, frame=0. Assert rst_n asynchronously mid-cycle -> outputs go FF before the next edge.
- Scan sweep, CLK_DIV=4, key=8'h1C, ascii=8'h61, count=8'h05, blank=0, after the first frame:
  - digits 0..5 show seg_n C6, F9, F9, 82, 92, C0 with an_n FE, FD, FB, F7, EF, DF;
  - each digit is held 4 cycles;
  - digits 6-7 show an_n=FF, seg_n=FF.
- Blanking: blank=1, count=8'h2A -> digits 0-3 show an_n=FF, seg_n=FF; digits 4/5 show 88/A4.
- Tear-free: change key 8'h1C -> 8'h3B while digit 1 is lit -> digits 1..3 of the same frame still show old values. After the next frame pulse, digit 0 = 83 and digit 1 = B0.
- Wrap: count steps 8'hFF -> 8'h00 across two frames -> digits 4/5 show 8E/8E, then C0/C0. frame pulses exactly once per 32 cycles (CLK_DIV=4).
- Reset mid-frame at digit 3 with CLK_DIV=4 -> after release, the first lit digit is digit 0 with the zero snapshot (seg_n=C0, an_n=FE if blank=0 was captured). frame first pulses 32 cycles after release.
